// File: rtl/age_ordered_rs_pkg.sv
// Shared configuration for the age-ordered reservation station:
// default tag/opcode widths and the opcode encodings.
package age_ordered_rs_pkg;

  localparam int ROB_LOG_DEF = 4;
  localparam int OP_LOG_DEF  = 6;
  localparam int XLEN        = 32;

  typedef enum logic [OP_LOG_DEF-1:0] {
    OP_ADD  = 6'h00,
    OP_SUB  = 6'h01,
    OP_AND  = 6'h02,
    OP_OR   = 6'h03,
    OP_XOR  = 6'h04,
    OP_SLL  = 6'h05,
    OP_SRL  = 6'h06,
    OP_SRA  = 6'h07,
    OP_SLT  = 6'h08,
    OP_SLTU = 6'h09,
    OP_LUI  = 6'h0a,
    OP_AUI  = 6'h0b,
    OP_BR   = 6'h10,
    OP_JAL  = 6'h11,
    OP_JALR = 6'h12,
    OP_LD   = 6'h20,
    OP_ST   = 6'h21
  } op_e;

endpackage

// File: rtl/age_select.sv
// Oldest-eligible picker: i_age[i][j] set means slot j is older than slot i.
// A slot wins when it is eligible and no eligible slot is older than it.
module age_select
  import age_ordered_rs_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]            i_elig,
  input  logic [DEPTH-1:0][DEPTH-1:0] i_age,
  output logic [DEPTH-1:0]            o_grant
);

  always_comb begin
    o_grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_grant[i] = i_elig[i] & ~(|(i_age[i] & i_elig));
    end
  end

endmodule

// File: rtl/age_ordered_rs.sv
// Reservation station with CDB wakeup, oldest-ready select via age matrix,
// and a single registered dispatch stage with valid/ready handshake.
module age_ordered_rs
  import age_ordered_rs_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int CDB_N   = 2,
  parameter int ROB_LOG = ROB_LOG_DEF,
  parameter int OP_LOG  = OP_LOG_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [OP_LOG-1:0]        issue_op,
  input  logic [31:0]              issue_vj,
  input  logic [31:0]              issue_vk,
  input  logic                     issue_rj,
  input  logic                     issue_rk,
  input  logic [ROB_LOG-1:0]       issue_qj,
  input  logic [ROB_LOG-1:0]       issue_qk,
  input  logic [31:0]              issue_imm,
  input  logic [31:0]              issue_pc,
  input  logic [ROB_LOG-1:0]       issue_dest,
  input  logic [CDB_N-1:0]         cdb_valid,
  input  logic [CDB_N*ROB_LOG-1:0] cdb_tag,
  input  logic [CDB_N*32-1:0]      cdb_value,
  output logic                     fu_valid,
  input  logic                     fu_ready,
  output logic [OP_LOG-1:0]        fu_op,
  output logic [31:0]              fu_vj,
  output logic [31:0]              fu_vk,
  output logic [31:0]              fu_imm,
  output logic [31:0]              fu_pc,
  output logic [ROB_LOG-1:0]       fu_dest,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [OP_LOG-1:0]  op;
    logic [31:0]        vj;
    logic [31:0]        vk;
    logic               rj;
    logic               rk;
    logic [ROB_LOG-1:0] qj;
    logic [ROB_LOG-1:0] qk;
    logic [31:0]        imm;
    logic [31:0]        pc;
    logic [ROB_LOG-1:0] dest;
  } ent_t;

  typedef struct packed {
    logic [OP_LOG-1:0]  op;
    logic [31:0]        vj;
    logic [31:0]        vk;
    logic [31:0]        imm;
    logic [31:0]        pc;
    logic [ROB_LOG-1:0] dest;
  } out_t;

  ent_t                       r_ent [DEPTH];
  logic [DEPTH-1:0]           r_busy;
  logic [DEPTH-1:0][DEPTH-1:0] r_age;
  logic [CW-1:0]              r_count;
  logic                       r_fu_valid;
  out_t                       r_fu;

  logic [32:0]      w_wj [DEPTH];
  logic [32:0]      w_wk [DEPTH];
  logic [32:0]      w_bj;
  logic [32:0]      w_bk;
  ent_t             w_new;
  ent_t             w_sel;
  logic [DEPTH-1:0] w_elig;
  logic [DEPTH-1:0] w_grant;
  logic [IW-1:0]    w_gnt_idx;
  logic [IW-1:0]    w_free_idx;
  logic             w_out_free;
  logic             w_disp;
  logic             w_iss;

  // {hit, value}; lowest channel index wins on multiple matches
  function automatic logic [32:0] f_cdb(
    input logic [ROB_LOG-1:0]       q,
    input logic [CDB_N-1:0]         v,
    input logic [CDB_N*ROB_LOG-1:0] t,
    input logic [CDB_N*32-1:0]      d
  );
    logic [32:0] r;
    r = '0;
    for (int c = CDB_N - 1; c >= 0; c--) begin
      if (v[c] && t[c*ROB_LOG +: ROB_LOG] == q)
        r = {1'b1, d[c*32 +: 32]};
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_wj[i] = f_cdb(r_ent[i].qj, cdb_valid, cdb_tag, cdb_value);
      w_wk[i] = f_cdb(r_ent[i].qk, cdb_valid, cdb_tag, cdb_value);
    end
  end

  assign w_bj = f_cdb(issue_qj, cdb_valid, cdb_tag, cdb_value);
  assign w_bk = f_cdb(issue_qk, cdb_valid, cdb_tag, cdb_value);

  always_comb begin
    w_new      = '0;
    w_new.op   = issue_op;
    w_new.qj   = issue_qj;
    w_new.qk   = issue_qk;
    w_new.imm  = issue_imm;
    w_new.pc   = issue_pc;
    w_new.dest = issue_dest;
    w_new.rj   = issue_rj | w_bj[32];
    w_new.rk   = issue_rk | w_bk[32];
    w_new.vj   = (!issue_rj && w_bj[32]) ? w_bj[31:0] : issue_vj;
    w_new.vk   = (!issue_rk && w_bk[32]) ? w_bk[31:0] : issue_vk;
  end

  always_comb begin
    w_free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_free_idx = IW'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_elig[i] = r_busy[i] & r_ent[i].rj & r_ent[i].rk;
    end
  end

  age_select #(
    .DEPTH(DEPTH)
  ) u_age_select (
    .i_elig (w_elig),
    .i_age  (r_age),
    .o_grant(w_grant)
  );

  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_grant[i]) w_gnt_idx = IW'(i);
    end
  end

  assign w_sel      = r_ent[w_gnt_idx];
  assign w_out_free = ~r_fu_valid | fu_ready;
  assign w_disp     = w_out_free & (|w_grant);
  assign w_iss      = issue_valid & issue_ready & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= '0;
      r_count    <= '0;
      r_fu_valid <= 1'b0;
      r_fu       <= '0;
    end else if (rdy) begin
      if (flush) begin
        r_busy     <= '0;
        r_count    <= '0;
        r_fu_valid <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_busy[i] && !r_ent[i].rj && w_wj[i][32]) begin
            r_ent[i].rj <= 1'b1;
            r_ent[i].vj <= w_wj[i][31:0];
          end
          if (r_busy[i] && !r_ent[i].rk && w_wk[i][32]) begin
            r_ent[i].rk <= 1'b1;
            r_ent[i].vk <= w_wk[i][31:0];
          end
        end
        if (w_out_free) r_fu_valid <= |w_grant;
        if (w_disp) begin
          r_busy[w_gnt_idx] <= 1'b0;
          r_fu.op   <= w_sel.op;
          r_fu.vj   <= w_sel.vj;
          r_fu.vk   <= w_sel.vk;
          r_fu.imm  <= w_sel.imm;
          r_fu.pc   <= w_sel.pc;
          r_fu.dest <= w_sel.dest;
        end
        // new slot is younger than every occupant; clearing its column
        // erases stale ordering left by the slot's previous owner
        if (w_iss) begin
          r_busy[w_free_idx] <= 1'b1;
          r_ent[w_free_idx]  <= w_new;
          r_age[w_free_idx]  <= r_busy;
          for (int j = 0; j < DEPTH; j++) begin
            r_age[j][w_free_idx] <= 1'b0;
          end
        end
        r_count <= r_count + CW'(w_iss) - CW'(w_disp);
      end
    end
  end

  assign issue_ready = r_count < FULL;
  assign count       = r_count;
  assign fu_valid    = r_fu_valid;
  assign fu_op       = r_fu.op;
  assign fu_vj       = r_fu.vj;
  assign fu_vk       = r_fu.vk;
  assign fu_imm      = r_fu.imm;
  assign fu_pc       = r_fu.pc;
  assign fu_dest     = r_fu.dest;

endmodule

// File: tb/tb_age_ordered_rs.sv
// Self-checking bench for age_ordered_rs: directed table, corner sequences
// and random traffic against an in-order queue reference model.
module tb_age_ordered_rs;
  import age_ordered_rs_pkg::*;

  localparam int DEPTH = 8;
  localparam int CDB_N = 2;
  localparam int RL    = 4;
  localparam int OL    = 6;

  logic              clk = 1'b0;
  logic              rst, rdy, flush;
  logic              issue_valid, issue_ready;
  logic [OL-1:0]     issue_op;
  logic [31:0]       issue_vj, issue_vk, issue_imm, issue_pc;
  logic              issue_rj, issue_rk;
  logic [RL-1:0]     issue_qj, issue_qk, issue_dest;
  logic [CDB_N-1:0]  cdb_valid;
  logic [CDB_N*RL-1:0] cdb_tag;
  logic [CDB_N*32-1:0] cdb_value;
  logic              fu_valid, fu_ready;
  logic [OL-1:0]     fu_op;
  logic [31:0]       fu_vj, fu_vk, fu_imm, fu_pc;
  logic [RL-1:0]     fu_dest;
  logic [3:0]        count;

  age_ordered_rs #(
    .DEPTH(DEPTH), .CDB_N(CDB_N), .ROB_LOG(RL), .OP_LOG(OL)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_rj(issue_rj), .issue_rk(issue_rk),
    .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_dest(issue_dest),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_op(fu_op), .fu_vj(fu_vj), .fu_vk(fu_vk),
    .fu_imm(fu_imm), .fu_pc(fu_pc), .fu_dest(fu_dest),
    .count(count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [35:0] act,
                     input logic [35:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // reference model: queue position is age, head is oldest
  typedef struct {
    logic [OL-1:0] op;
    logic [31:0]   vj, vk, imm, pc;
    logic          rj, rk;
    logic [RL-1:0] qj, qk, dest;
  } ment_t;

  ment_t mq[$];
  logic  m_ov;
  ment_t m_out;

  function automatic logic [32:0] lookup(input logic [RL-1:0] q);
    for (int c = 0; c < CDB_N; c++) begin
      if (cdb_valid[c] && cdb_tag[c*RL +: RL] == q)
        return {1'b1, cdb_value[c*32 +: 32]};
    end
    return 33'd0;
  endfunction

  task automatic model_step();
    logic [32:0] h;
    ment_t e;
    int k;
    int pre;
    if (rst) begin
      mq.delete();
      m_ov  = 1'b0;
      m_out = '{default: '0};
      return;
    end
    if (!rdy) return;
    if (flush) begin
      mq.delete();
      m_ov = 1'b0;
      return;
    end
    pre = mq.size();
    if (!m_ov || fu_ready) begin
      k = -1;
      for (int i = 0; i < mq.size(); i++)
        if (k < 0 && mq[i].rj && mq[i].rk) k = i;
      if (k >= 0) begin
        m_out = mq[k];
        m_ov  = 1'b1;
        mq.delete(k);
      end else begin
        m_ov = 1'b0;
      end
    end
    for (int i = 0; i < mq.size(); i++) begin
      if (!mq[i].rj) begin
        h = lookup(mq[i].qj);
        if (h[32]) begin mq[i].rj = 1'b1; mq[i].vj = h[31:0]; end
      end
      if (!mq[i].rk) begin
        h = lookup(mq[i].qk);
        if (h[32]) begin mq[i].rk = 1'b1; mq[i].vk = h[31:0]; end
      end
    end
    if (issue_valid && pre < DEPTH) begin
      e.op = issue_op; e.imm = issue_imm; e.pc = issue_pc;
      e.dest = issue_dest; e.qj = issue_qj; e.qk = issue_qk;
      e.rj = issue_rj; e.vj = issue_vj;
      e.rk = issue_rk; e.vk = issue_vk;
      if (!issue_rj) begin
        h = lookup(issue_qj);
        if (h[32]) begin e.rj = 1'b1; e.vj = h[31:0]; end
      end
      if (!issue_rk) begin
        h = lookup(issue_qk);
        if (h[32]) begin e.rk = 1'b1; e.vk = h[31:0]; end
      end
      mq.push_back(e);
    end
  endtask

  logic        rec = 1'b0;
  logic [35:0] got[$];

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("fu_valid", 36'(fu_valid), 36'(m_ov));
    chk("count", 36'(count), 36'(mq.size()));
    chk("issue_ready", 36'(issue_ready), 36'(mq.size() < DEPTH));
    chk("fu_dest", 36'(fu_dest), 36'(m_out.dest));
    chk("fu_vj", 36'(fu_vj), 36'(m_out.vj));
    chk("fu_vk", 36'(fu_vk), 36'(m_out.vk));
    chk("fu_op", 36'(fu_op), 36'(m_out.op));
    chk("fu_imm_pc", 36'(fu_imm ^ fu_pc), 36'(m_out.imm ^ m_out.pc));
    if (rec && fu_valid) got.push_back({fu_dest, fu_vj});
  endtask

  task automatic idle();
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    issue_valid = 1'b0; issue_rj = 1'b1; issue_rk = 1'b1;
    issue_qj = '0; issue_qk = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
  endtask

  task automatic set_issue(input logic [3:0] dest, input logic rj,
                           input logic [3:0] qj, input logic [31:0] vj,
                           input logic rk, input logic [3:0] qk,
                           input logic [31:0] vk);
    issue_valid = 1'b1; issue_op = OP_ADD;
    issue_dest = dest; issue_rj = rj; issue_qj = qj; issue_vj = vj;
    issue_rk = rk; issue_qk = qk; issue_vk = vk;
    issue_imm = {28'h0, dest}; issue_pc = 32'h1000 + {28'h0, dest};
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_got(input string nm, input int i,
                         input logic [35:0] exp, input logic full);
    logic [35:0] a;
    a = (i < got.size()) ? got[i] : 36'hfffffffff;
    if (full) chk(nm, a, exp);
    else chk(nm, 36'(a[35:32]), 36'(exp[35:32]));
  endtask

  typedef struct {
    bit          iv;
    bit          rk;
    logic [3:0]  qk;
    logic [3:0]  dest;
    logic [31:0] vk;
    bit          cv;
    logic [3:0]  ct;
    logic [31:0] cval;
    bit          ev;
    logic [3:0]  edest;
    logic [31:0] evk;
    int          ecnt;
  } vec_t;

  vec_t vt[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1, 1, 0, 1, 32'h101,  0, 0, 0,        0, 0, 0,        1};
    vt[1]  = '{1, 1, 0, 2, 32'h102,  0, 0, 0,        1, 1, 32'h101,  1};
    vt[2]  = '{1, 1, 0, 3, 32'h103,  0, 0, 0,        1, 2, 32'h102,  1};
    vt[3]  = '{0, 1, 0, 0, 0,        0, 0, 0,        1, 3, 32'h103,  0};
    vt[4]  = '{0, 1, 0, 0, 0,        0, 0, 0,        0, 0, 0,        0};
    vt[5]  = '{1, 0, 3, 7, 32'hdead, 1, 3, 32'habcd, 0, 0, 0,        1};
    vt[6]  = '{0, 1, 0, 0, 0,        0, 0, 0,        1, 7, 32'habcd, 0};
    vt[7]  = '{0, 1, 0, 0, 0,        0, 0, 0,        0, 0, 0,        0};
    vt[8]  = '{1, 0, 4, 9, 32'h5555, 0, 0, 0,        0, 0, 0,        1};
    vt[9]  = '{0, 1, 0, 0, 0,        1, 4, 32'h4444, 0, 0, 0,        1};
    vt[10] = '{0, 1, 0, 0, 0,        0, 0, 0,        1, 9, 32'h4444, 0};

    issue_op = '0; issue_vj = '0; issue_vk = '0;
    issue_imm = '0; issue_pc = '0; issue_dest = '0;
    fu_ready = 1'b1;
    do_reset();
    chk("rst_count", 36'(count), 36'd0);
    chk("rst_fu_valid", 36'(fu_valid), 36'd0);
    chk("rst_payload", 36'(fu_vj | fu_vk | fu_pc | fu_imm), 36'd0);
    chk("rst_issue_ready", 36'(issue_ready), 36'd1);

    // in-order dispatch latency, same-cycle bypass, wakeup latency
    for (int i = 0; i < 11; i++) begin
      idle();
      if (vt[i].iv)
        set_issue(vt[i].dest, 1'b1, 4'd0, 32'h0, vt[i].rk, vt[i].qk,
                  vt[i].vk);
      cdb_valid = {1'b0, vt[i].cv};
      cdb_tag   = {4'd0, vt[i].ct};
      cdb_value = {32'd0, vt[i].cval};
      tick();
      chk($sformatf("tbl%0d_valid", i), 36'(fu_valid), 36'(vt[i].ev));
      chk($sformatf("tbl%0d_count", i), 36'(count), 36'(vt[i].ecnt));
      if (vt[i].ev) begin
        chk($sformatf("tbl%0d_dest", i), 36'(fu_dest), 36'(vt[i].edest));
        chk($sformatf("tbl%0d_vk", i), 36'(fu_vk), 36'(vt[i].evk));
      end
    end

    // younger ready op overtakes an older waiting one
    do_reset();
    got.delete(); rec = 1'b1;
    set_issue(4'd1, 1'b0, 4'd5, 32'h0, 1'b1, 4'd0, 32'h11); tick();
    set_issue(4'd2, 1'b1, 4'd0, 32'h22, 1'b1, 4'd0, 32'h22); tick();
    idle(); tick(); tick(); tick();
    cdb_valid = 2'b11; cdb_tag = {4'd5, 4'd6};
    cdb_value = {32'h1234, 32'hffff};
    tick();
    idle();
    for (int i = 0; i < 4; i++) tick();
    rec = 1'b0;
    chk("wake_ndisp", 36'(got.size()), 36'd2);
    chk_got("wake_first", 0, {4'd2, 32'h22}, 1'b1);
    chk_got("wake_second", 1, {4'd1, 32'h1234}, 1'b1);

    // full station with a stalled FU
    do_reset();
    fu_ready = 1'b0;
    for (int k = 0; k < DEPTH + 1; k++) begin
      set_issue(4'(k), 1'b1, 4'd0, 32'(k), 1'b1, 4'd0, 32'(k));
      tick();
    end
    idle();
    chk("full_count", 36'(count), 36'd8);
    chk("full_ready", 36'(issue_ready), 36'd0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("hold_valid", 36'(fu_valid), 36'd1);
      chk("hold_dest", 36'(fu_dest), 36'd0);
    end
    fu_ready = 1'b1;
    tick();
    chk("drain_count", 36'(count), 36'd7);
    chk("drain_ready", 36'(issue_ready), 36'd1);
    chk("drain_dest", 36'(fu_dest), 36'd1);
    for (int k = 0; k < 10; k++) tick();

    // slot 0 reused while older entries still wait
    do_reset();
    got.delete(); rec = 1'b1;
    set_issue(4'd10, 1'b0, 4'd8, 32'h0, 1'b1, 4'd0, 32'h0); tick();
    set_issue(4'd11, 1'b0, 4'd9, 32'h0, 1'b1, 4'd0, 32'h0); tick();
    set_issue(4'd12, 1'b0, 4'd9, 32'h0, 1'b1, 4'd0, 32'h0); tick();
    idle(); cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd8};
    cdb_value = {32'd0, 32'h88};
    tick();
    idle(); tick();
    set_issue(4'd13, 1'b0, 4'd9, 32'h0, 1'b1, 4'd0, 32'h0); tick();
    idle(); cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd9};
    cdb_value = {32'd0, 32'h99};
    tick();
    idle();
    for (int i = 0; i < 6; i++) tick();
    rec = 1'b0;
    chk("reuse_ndisp", 36'(got.size()), 36'd4);
    chk_got("reuse_0", 0, {4'd10, 32'h88}, 1'b1);
    chk_got("reuse_1", 1, {4'd11, 32'h0}, 1'b0);
    chk_got("reuse_2", 2, {4'd12, 32'h0}, 1'b0);
    chk_got("reuse_3", 3, {4'd13, 32'h99}, 1'b1);

    // flush beats a concurrent issue and the pending dispatch
    do_reset();
    fu_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_issue(4'(k), 1'b1, 4'd0, 32'(k), 1'b1, 4'd0, 32'(k));
      tick();
    end
    chk("pre_flush_count", 36'(count), 36'd5);
    chk("pre_flush_valid", 36'(fu_valid), 36'd1);
    flush = 1'b1;
    set_issue(4'd15, 1'b1, 4'd0, 32'h0, 1'b1, 4'd0, 32'h0);
    tick();
    idle();
    chk("flush_count", 36'(count), 36'd0);
    chk("flush_valid", 36'(fu_valid), 36'd0);
    tick();
    chk("flush_drop", 36'(count), 36'd0);

    // random traffic against the model
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst         = (cyc == 1500);
      rdy         = ($urandom_range(0, 7) != 0);
      flush       = ($urandom_range(0, 63) == 0);
      issue_valid = ($urandom_range(0, 2) != 0);
      issue_op    = OL'($urandom);
      issue_vj    = $urandom;
      issue_vk    = $urandom;
      issue_imm   = $urandom;
      issue_pc    = $urandom;
      issue_rj    = 1'($urandom);
      issue_rk    = 1'($urandom);
      issue_qj    = 4'($urandom_range(0, 7));
      issue_qk    = 4'($urandom_range(0, 7));
      issue_dest  = 4'($urandom);
      cdb_valid   = 2'($urandom);
      cdb_tag     = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
      cdb_value   = {$urandom, $urandom};
      fu_ready    = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
